// File: rtl/uart_boot_loader.sv
// Boot sequencer: assembles little-endian words from the UART byte stream, fills IMEM then DMEM,
// then releases the CPU from reset. Define LOADER_CKSUM_EN to verify a trailing 32-bit sum first.
module uart_boot_loader #(
    parameter int IMEM_ENTRIES = 4096,
    parameter int DMEM_ENTRIES = 4096,
    parameter int IADDR_W      = $clog2(IMEM_ENTRIES),
    parameter int DADDR_W      = $clog2(DMEM_ENTRIES)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               rvalid_i,
    output logic               rready_o,
    input  logic [7:0]         rdata_i,
    output logic               imem_we_o,
    output logic [IADDR_W-1:0] imem_addr_o,
    output logic [31:0]        imem_wdata_o,
    output logic               dmem_we_o,
    output logic [DADDR_W-1:0] dmem_addr_o,
    output logic [31:0]        dmem_wdata_o,
    output logic               cpu_rst_no,
    output logic               done_o,
    output logic               err_o
);

    typedef enum logic [2:0] {
        LOAD_IMEM,
        LOAD_DMEM,
        CKSUM,
        DONE,
        ERROR
    } state_t;

    localparam logic [IADDR_W-1:0] IMEM_LAST = IADDR_W'(IMEM_ENTRIES - 1);
    localparam logic [DADDR_W-1:0] DMEM_LAST = DADDR_W'(DMEM_ENTRIES - 1);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [23:0] byte_buf;
    logic        rready;
    logic [31:0] word;
    logic        accept;

    assign rready_o = rready;
    assign accept   = rvalid_i & rready;
    assign word     = {rdata_i, byte_buf};

`ifdef LOADER_CKSUM_EN
    logic [31:0] sum;
    logic        err;
    assign err_o = err;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= LOAD_IMEM;
            byte_cnt     <= 2'd0;
            byte_buf     <= '0;
            rready       <= 1'b0;
            imem_we_o    <= 1'b0;
            imem_addr_o  <= '0;
            imem_wdata_o <= '0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            cpu_rst_no   <= 1'b0;
            done_o       <= 1'b0;
`ifdef LOADER_CKSUM_EN
            sum          <= '0;
            err          <= 1'b0;
`endif
        end else begin
            imem_we_o <= 1'b0;
            dmem_we_o <= 1'b0;

            // Addresses advance in the cycle after their strobe; IMEM clears after its last word,
            // DMEM parks on its last word so neither ever wraps into a fresh write.
            if (imem_we_o) begin
                imem_addr_o <= (imem_addr_o == IMEM_LAST) ? '0 : imem_addr_o + IADDR_W'(1);
            end
            if (dmem_we_o && dmem_addr_o != DMEM_LAST) begin
                dmem_addr_o <= dmem_addr_o + DADDR_W'(1);
            end

            if (state == DONE) begin
                done_o     <= 1'b1;
                cpu_rst_no <= 1'b1;
            end
`ifdef LOADER_CKSUM_EN
            if (state == ERROR) begin
                err <= 1'b1;
            end
`endif

            if (state == LOAD_IMEM || state == LOAD_DMEM || state == CKSUM) begin
                rready <= 1'b1;
            end

            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: byte_buf[7:0]   <= rdata_i;
                    2'd1: byte_buf[15:8]  <= rdata_i;
                    2'd2: byte_buf[23:16] <= rdata_i;
                    default: begin
                        case (state)
                            LOAD_IMEM: begin
                                imem_we_o    <= 1'b1;
                                imem_wdata_o <= word;
`ifdef LOADER_CKSUM_EN
                                sum          <= sum + word;
`endif
                                // Switch now so a byte arriving during the strobe lands in DMEM.
                                if (imem_addr_o == IMEM_LAST) begin
                                    state <= LOAD_DMEM;
                                end
                            end
                            LOAD_DMEM: begin
                                dmem_we_o    <= 1'b1;
                                dmem_wdata_o <= word;
`ifdef LOADER_CKSUM_EN
                                sum          <= sum + word;
                                if (dmem_addr_o == DMEM_LAST) begin
                                    state <= CKSUM;
                                end
`else
                                if (dmem_addr_o == DMEM_LAST) begin
                                    state  <= DONE;
                                    rready <= 1'b0;
                                end
`endif
                            end
`ifdef LOADER_CKSUM_EN
                            CKSUM: begin
                                state  <= (word == sum) ? DONE : ERROR;
                                rready <= 1'b0;
                            end
`endif
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader sized to a 4-word IMEM and 2-word DMEM.
// Covers back-to-back and UART-paced loads, mid-load reset, post-DONE bytes and the optional checksum.
module tb_uart_boot_loader;

    localparam int IMEM_ENTRIES  = 4;
    localparam int DMEM_ENTRIES  = 2;
    localparam int IADDR_W       = 2;
    localparam int DADDR_W       = 1;
    localparam int CLK_FREQ_MHZ  = 1;
    localparam int UART_BAUDRATE = 115200;
    localparam int BYTE_CYCLES   = (CLK_FREQ_MHZ * 1000000 / UART_BAUDRATE) * 10;

    localparam logic [31:0] EXP_IMEM [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    localparam logic [31:0] EXP_DMEM [2] = '{32'h13121110, 32'h17161514};
    localparam logic [31:0] EXP_SUM      = 32'h4E48423C;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               rvalid;
    logic               rready;
    logic [7:0]         rdata;
    logic               imem_we;
    logic [IADDR_W-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               dmem_we;
    logic [DADDR_W-1:0] dmem_addr;
    logic [31:0]        dmem_wdata;
    logic               cpu_rst_n;
    logic               done;
    logic               err;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    logic [31:0] imem_m [4];
    logic [31:0] dmem_m [2];
    int  n_istb, n_dstb, n_bad, first_iaddr, last_dstb, first_done;
    logic prev_i, prev_d;

    uart_boot_loader #(
        .IMEM_ENTRIES(IMEM_ENTRIES),
        .DMEM_ENTRIES(DMEM_ENTRIES),
        .IADDR_W     (IADDR_W),
        .DADDR_W     (DADDR_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rvalid_i    (rvalid),
        .rready_o    (rready),
        .rdata_i     (rdata),
        .imem_we_o   (imem_we),
        .imem_addr_o (imem_addr),
        .imem_wdata_o(imem_wdata),
        .dmem_we_o   (dmem_we),
        .dmem_addr_o (dmem_addr),
        .dmem_wdata_o(dmem_wdata),
        .cpu_rst_no  (cpu_rst_n),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory images and strobe statistics, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_we) begin
                imem_m[imem_addr] = imem_wdata;
                n_istb++;
                if (first_iaddr < 0) first_iaddr = int'(imem_addr);
            end
            if (dmem_we) begin
                dmem_m[dmem_addr] = dmem_wdata;
                n_dstb++;
                last_dstb = cyc;
            end
            if ((imem_we && prev_i) || (dmem_we && prev_d) || (imem_we && dmem_we)) n_bad++;
            prev_i = imem_we;
            prev_d = dmem_we;
            if (done && first_done < 0) first_done = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_scoreboard();
        for (int i = 0; i < 4; i++) imem_m[i] = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) dmem_m[i] = 32'hDEADBEEF;
        n_istb = 0; n_dstb = 0; n_bad = 0;
        first_iaddr = -1; last_dstb = -1; first_done = -1;
        prev_i = 1'b0; prev_d = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        rvalid = 1'b1;
        rdata  = b;
        n = 0;
        while (!rready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("rready_timeout", {31'b0, rready}, 32'd1);
            rvalid = 1'b0;
        end else begin
            @(posedge clk);
            #1 rvalid = 1'b0;
        end
    endtask

    task automatic send_image(input int gap, input logic [31:0] sum_delta);
        logic [31:0] s;
        for (int i = 0; i < 24; i++) begin
            send_byte(8'(i));
            repeat (gap) @(negedge clk);
        end
        s = EXP_SUM + sum_delta;
`ifdef LOADER_CKSUM_EN
        for (int k = 0; k < 4; k++) send_byte(s[8*k +: 8]);
`endif
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!done && !err && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("end_timeout", {31'b0, done | err}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 4; i++) check($sformatf("%s_imem%0d", tag, i), imem_m[i], EXP_IMEM[i]);
        for (int i = 0; i < 2; i++) check($sformatf("%s_dmem%0d", tag, i), dmem_m[i], EXP_DMEM[i]);
    endtask

    // Drops reset off the clock edge to observe the asynchronous effect, then releases cleanly.
    task automatic glitch_reset(input string tag);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check({tag, "_cpu_rst"}, {31'b0, cpu_rst_n}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_iaddr"}, {30'b0, imem_addr}, 32'd0);
        clear_scoreboard();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        rvalid = 1'b0;
        rdata  = 8'h00;
        clear_scoreboard();
        repeat (3) @(negedge clk);
        check("rst_rready", {31'b0, rready}, 32'd0);
        check("rst_imem_we", {31'b0, imem_we}, 32'd0);
        check("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
        check("rst_imem_addr", {30'b0, imem_addr}, 32'd0);
        check("rst_dmem_addr", {31'b0, dmem_addr}, 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        check("rst_cpu_rst", {31'b0, cpu_rst_n}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back stream
        send_image(0, 32'd0);
        wait_end();
        check_mem("b2b");
        check("b2b_istb", n_istb, 32'd4);
        check("b2b_dstb", n_dstb, 32'd2);
        check("b2b_pulse", n_bad, 32'd0);
        check("b2b_done", {31'b0, done}, 32'd1);
        check("b2b_cpu_rst", {31'b0, cpu_rst_n}, 32'd1);
        check("b2b_err", {31'b0, err}, 32'd0);
        check("b2b_rready", {31'b0, rready}, 32'd0);
`ifndef LOADER_CKSUM_EN
        check("b2b_done_lat", first_done, last_dstb + 1);
`endif

        // UART-paced stream
        glitch_reset("pre_uart");
        send_image(BYTE_CYCLES, 32'd0);
        wait_end();
        check_mem("uart");
        check("uart_strobes", n_istb + n_dstb, 32'd6);
        check("uart_pulse", n_bad, 32'd0);
        check("uart_done", {31'b0, done}, 32'd1);

        // Bytes after DONE are refused
        @(negedge clk);
        rvalid = 1'b1;
        rdata  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("extra_rready%0d", i), {31'b0, rready}, 32'd0);
            @(negedge clk);
        end
        rvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("extra_strobes", n_istb + n_dstb, 32'd6);
        check_mem("extra");
        check("extra_done", {31'b0, done}, 32'd1);

        // Reset mid-load, then full reload
        glitch_reset("pre_glitch");
        for (int i = 0; i < 9; i++) send_byte(8'(i));
        check("glitch_partial_istb", n_istb, 32'd2);
        glitch_reset("glitch");
        send_image(0, 32'd0);
        wait_end();
        check_mem("reload");
        check("reload_first_iaddr", first_iaddr, 32'd0);
        check("reload_strobes", n_istb + n_dstb, 32'd6);
        check("reload_done", {31'b0, done}, 32'd1);
        check("reload_cpu_rst", {31'b0, cpu_rst_n}, 32'd1);

`ifdef LOADER_CKSUM_EN
        // Wrong reference sum
        glitch_reset("pre_bad_sum");
        send_image(0, 32'd1);
        wait_end();
        check("bad_sum_err", {31'b0, err}, 32'd1);
        check("bad_sum_done", {31'b0, done}, 32'd0);
        check("bad_sum_cpu_rst", {31'b0, cpu_rst_n}, 32'd0);
        check("bad_sum_rready", {31'b0, rready}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
